// File: rtl/prbs_ctrl_pkg.sv
// Shared types and constants for the PRBS run controller and its shadow registers.
package prbs_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_RESET   = 3'd2,
        ST_SETTLE  = 3'd3,
        ST_RUN     = 3'd4,
        ST_DRAIN   = 3'd5,
        ST_PROTECT = 3'd6
    } state_e;

    localparam logic [1:0] ADDR_PN    = 2'd0;
    localparam logic [1:0] ADDR_RATE  = 2'd1;
    localparam logic [1:0] ADDR_SHAPE = 2'd2;
    localparam logic [1:0] ADDR_CTRL  = 2'd3;

    localparam logic [3:0] PN7  = 4'd0;
    localparam logic [3:0] PN9  = 4'd1;
    localparam logic [3:0] PN11 = 4'd2;
    localparam logic [3:0] PN15 = 4'd3;
    localparam logic [3:0] PN20 = 4'd4;
    localparam logic [3:0] PN23 = 4'd5;
    localparam logic [3:0] PN31 = 4'd6;

    localparam logic [31:0] DEFAULT_BITRATE = 32'h0100_0000;

    typedef struct packed {
        logic [3:0]  pn;
        logic [31:0] rate;
        logic [7:0]  edge_time;
        logic [1:0]  filt;
    } cfg_t;

    function automatic cfg_t cfg_reset(input logic [31:0] rate);
        cfg_t c;
        c      = '0;
        c.rate = rate;
        return c;
    endfunction

endpackage

// File: rtl/prbs_cfg_shadow_regs.sv
// Host-visible shadow configuration, apply validation, sticky error and pending flag.
module prbs_cfg_shadow_regs #(
    parameter logic [3:0]  PN_MAX_CODE = 4'd6,
    parameter logic [31:0] RESET_RATE  = 32'h0100_0000
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 host_wr_en_i,
    input  logic [1:0]           host_addr_i,
    input  logic [31:0]          host_wdata_i,
    input  logic                 commit_i,
    output logic                 run_o,
    output logic                 accept_o,
    output logic                 pending_o,
    output logic                 cfg_error_o,
    output prbs_ctrl_pkg::cfg_t  staged_o
);
    import prbs_ctrl_pkg::*;

    cfg_t shadow_q, shadow_d;
    cfg_t staged_q, staged_d;
    logic run_q, run_d;
    logic pend_q, pend_d;
    logic err_q, err_d;
    logic apply, valid;

    assign apply    = host_wr_en_i && (host_addr_i == ADDR_CTRL) && host_wdata_i[1];
    assign valid    = (shadow_q.pn <= PN_MAX_CODE) && (shadow_q.rate != '0);
    assign accept_o = apply && valid;

    always_comb begin
        shadow_d = shadow_q;
        run_d    = run_q;
        if (host_wr_en_i) begin
            case (host_addr_i)
                ADDR_PN:   shadow_d.pn   = host_wdata_i[3:0];
                ADDR_RATE: shadow_d.rate = host_wdata_i;
                ADDR_SHAPE: begin
                    shadow_d.filt      = host_wdata_i[9:8];
                    shadow_d.edge_time = host_wdata_i[7:0];
                end
                default:   run_d = host_wdata_i[0];
            endcase
        end
    end

    // Snapshot validated shadows so later host writes cannot leak an unchecked value into LOAD.
    assign staged_d = accept_o ? shadow_q : staged_q;
    assign pend_d   = accept_o | (pend_q & ~commit_i);
    assign err_d    = apply ? ~valid : err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shadow_q <= cfg_reset(RESET_RATE);
            staged_q <= cfg_reset(RESET_RATE);
            run_q    <= 1'b0;
            pend_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            staged_q <= staged_d;
            run_q    <= run_d;
            pend_q   <= pend_d;
            err_q    <= err_d;
        end
    end

    assign run_o       = run_q;
    assign pending_o   = pend_q;
    assign cfg_error_o = err_q;
    assign staged_o    = staged_q;

endmodule

// File: rtl/prbs_run_controller.sv
// Run sequencer for the PRBS datapath: commits config, holds core reset, settles, unmutes.
module prbs_run_controller #(
    parameter int unsigned RST_CYCLES      = 4,
    parameter int unsigned SETTLE_TICKS    = 2,
    parameter logic [3:0]  PN_MAX_CODE     = 4'd6,
    parameter logic [31:0] DEFAULT_BITRATE = 32'h0100_0000
) (
    input  logic        dac_clk,
    input  logic        reset_n,
    input  logic        host_wr_en,
    input  logic [1:0]  host_addr,
    input  logic [31:0] host_wdata,
    input  logic        ch_load_protect,
    input  logic        bit_tick,
    output logic [3:0]  prbs_pn_select_out,
    output logic [31:0] prbs_bit_rate_out,
    output logic [7:0]  prbs_edge_time_out,
    output logic [1:0]  filter_strength_out,
    output logic        prbs_core_rst_n,
    output logic        dac_mute,
    output logic        busy,
    output logic        cfg_error,
    output logic [2:0]  state_dbg
);
    import prbs_ctrl_pkg::*;

    localparam int RW = (RST_CYCLES > 0) ? $clog2(RST_CYCLES + 1) : 1;
    localparam int TW = (SETTLE_TICKS > 0) ? $clog2(SETTLE_TICKS + 1) : 1;
    localparam logic [RW-1:0] RST_LOAD  = RW'(RST_CYCLES);
    localparam logic [TW-1:0] TICK_LOAD = TW'(SETTLE_TICKS);

    logic [1:0] sync_q;
    logic       rst_n;

    // Assert asynchronously, release two clocks later.
    always_ff @(posedge dac_clk or negedge reset_n) begin
        if (!reset_n) sync_q <= 2'b00;
        else          sync_q <= {sync_q[0], 1'b1};
    end
    assign rst_n = sync_q[1];

    logic  run, accept, pending, commit, pend_now;
    cfg_t  staged, active_q;

    prbs_cfg_shadow_regs #(
        .PN_MAX_CODE (PN_MAX_CODE),
        .RESET_RATE  (DEFAULT_BITRATE)
    ) u_shadow (
        .clk_i        (dac_clk),
        .rst_ni       (rst_n),
        .host_wr_en_i (host_wr_en),
        .host_addr_i  (host_addr),
        .host_wdata_i (host_wdata),
        .commit_i     (commit),
        .run_o        (run),
        .accept_o     (accept),
        .pending_o    (pending),
        .cfg_error_o  (cfg_error),
        .staged_o     (staged)
    );

    state_e        state_q, state_d;
    logic [RW-1:0] rcnt_q;
    logic [TW-1:0] tcnt_q;
    logic          core_rst_q, mute_q, busy_q;

    assign pend_now = pending | accept;

    always_comb begin
        state_d = state_q;
        if (state_q != ST_IDLE && ch_load_protect) begin
            state_d = ST_PROTECT;
        end else begin
            case (state_q)
                ST_IDLE:   if (run) state_d = ST_LOAD;
                ST_LOAD:   state_d = ST_RESET;
                ST_RESET: begin
                    if (!run)                    state_d = ST_IDLE;
                    else if (rcnt_q <= RW'(1))   state_d = ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (!run)                                  state_d = ST_IDLE;
                    else if (bit_tick && tcnt_q <= TW'(1))     state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (!run)          state_d = ST_IDLE;
                    else if (pend_now) state_d = ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (!run)          state_d = ST_IDLE;
                    else if (bit_tick) state_d = ST_LOAD;
                end
                ST_PROTECT: begin
                    if (!run)          state_d = ST_IDLE;
                    else if (pend_now) state_d = ST_LOAD;
                    else               state_d = ST_SETTLE;
                end
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    assign commit = (state_q == ST_LOAD) && (state_d == ST_RESET);

    always_ff @(posedge dac_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rcnt_q     <= '0;
            tcnt_q     <= '0;
            core_rst_q <= 1'b0;
            mute_q     <= 1'b1;
            busy_q     <= 1'b0;
            active_q   <= cfg_reset(DEFAULT_BITRATE);
        end else begin
            state_q <= state_d;
            if (commit) active_q <= staged;

            if (state_d == ST_RESET && state_q != ST_RESET)
                rcnt_q <= RST_LOAD;
            else if (state_q == ST_RESET && rcnt_q != '0)
                rcnt_q <= rcnt_q - RW'(1);

            if (state_d == ST_SETTLE && state_q != ST_SETTLE)
                tcnt_q <= TICK_LOAD;
            else if (state_q == ST_SETTLE && bit_tick && tcnt_q != '0)
                tcnt_q <= tcnt_q - TW'(1);

            unique case (state_d)
                ST_IDLE, ST_LOAD, ST_RESET: begin
                    core_rst_q <= 1'b0;
                    mute_q     <= 1'b1;
                end
                ST_RUN: begin
                    core_rst_q <= 1'b1;
                    mute_q     <= 1'b0;
                end
                default: begin
                    core_rst_q <= 1'b1;
                    mute_q     <= 1'b1;
                end
            endcase
            busy_q <= !(state_d inside {ST_IDLE, ST_RUN});
        end
    end

    assign prbs_pn_select_out  = active_q.pn;
    assign prbs_bit_rate_out   = active_q.rate;
    assign prbs_edge_time_out  = active_q.edge_time;
    assign filter_strength_out = active_q.filt;
    assign prbs_core_rst_n     = core_rst_q;
    assign dac_mute            = mute_q | ch_load_protect;
    assign busy                = busy_q;
    assign state_dbg           = state_q;

endmodule

// File: tb/tb_prbs_run_controller.sv
// Directed bench for prbs_run_controller: start-up, apply, reject, protect, async reset.
module tb_prbs_run_controller;

    logic        dac_clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        host_wr_en = 1'b0;
    logic [1:0]  host_addr = '0;
    logic [31:0] host_wdata = '0;
    logic        ch_load_protect = 1'b0;
    logic        bit_tick = 1'b0;
    logic [3:0]  pn;
    logic [31:0] rate;
    logic [7:0]  edge_t;
    logic [1:0]  filt;
    logic        core_rst_n, mute, busy, err;
    logic [2:0]  st;

    int errors = 0;
    int checks = 0;

    always #5 dac_clk = ~dac_clk;

    prbs_run_controller dut (
        .dac_clk             (dac_clk),
        .reset_n             (reset_n),
        .host_wr_en          (host_wr_en),
        .host_addr           (host_addr),
        .host_wdata          (host_wdata),
        .ch_load_protect     (ch_load_protect),
        .bit_tick            (bit_tick),
        .prbs_pn_select_out  (pn),
        .prbs_bit_rate_out   (rate),
        .prbs_edge_time_out  (edge_t),
        .filter_strength_out (filt),
        .prbs_core_rst_n     (core_rst_n),
        .dac_mute            (mute),
        .busy                (busy),
        .cfg_error           (err),
        .state_dbg           (st)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge dac_clk);
        @(negedge dac_clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        host_wr_en = 1'b1;
        host_addr  = a;
        host_wdata = d;
        cyc();
        host_wr_en = 1'b0;
    endtask

    task automatic tk();
        bit_tick = 1'b1;
        cyc();
        bit_tick = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"}, 32'(st), 32'd0);
        chk({tag, "_pn"}, 32'(pn), 32'd0);
        chk({tag, "_rate"}, rate, 32'h0100_0000);
        chk({tag, "_edge"}, 32'(edge_t), 32'd0);
        chk({tag, "_filt"}, 32'(filt), 32'd0);
        chk({tag, "_corerst"}, 32'(core_rst_n), 32'd0);
        chk({tag, "_mute"}, 32'(mute), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        #1 reset_n = 1'b0;
        repeat (3) @(negedge dac_clk);
        chk_reset_vals("rst");
        reset_n = 1'b1;
        repeat (4) cyc();
        chk("idle_hold", 32'(st), 32'd0);

        // Start-up: run=1, 4 cycles of core reset, 2 ticks of settle
        wr(2'd3, 32'h1);
        chk("s1_idle_still", 32'(st), 32'd0);
        cyc();
        chk("s1_load", 32'(st), 32'd1);
        chk("s1_load_corerst", 32'(core_rst_n), 32'd0);
        chk("s1_load_busy", 32'(busy), 32'd1);
        cyc();
        chk("s1_reset", 32'(st), 32'd2);
        repeat (3) cyc();
        chk("s1_reset_last", 32'(st), 32'd2);
        chk("s1_reset_corerst", 32'(core_rst_n), 32'd0);
        tk();
        chk("s1_settle", 32'(st), 32'd3);
        chk("s1_settle_corerst", 32'(core_rst_n), 32'd1);
        chk("s1_settle_mute", 32'(mute), 32'd1);
        tk();
        chk("s1_settle_tick1", 32'(st), 32'd3);
        repeat (6) cyc();
        chk("s1_settle_wait", 32'(st), 32'd3);
        chk("s1_settle_wait_mute", 32'(mute), 32'd1);
        tk();
        chk("s1_run", 32'(st), 32'd4);
        chk("s1_run_mute", 32'(mute), 32'd0);
        chk("s1_run_busy", 32'(busy), 32'd0);
        chk("s1_run_corerst", 32'(core_rst_n), 32'd1);

        // Apply in RUN: drain to tick, reload, reset, settle
        wr(2'd0, 32'd3);
        wr(2'd1, 32'h0200_0000);
        chk("s2_shadow_pn", 32'(pn), 32'd0);
        chk("s2_shadow_rate", rate, 32'h0100_0000);
        chk("s2_shadow_mute", 32'(mute), 32'd0);
        wr(2'd3, 32'h3);
        chk("s2_drain", 32'(st), 32'd5);
        chk("s2_drain_mute", 32'(mute), 32'd1);
        chk("s2_drain_pn", 32'(pn), 32'd0);
        repeat (3) cyc();
        chk("s2_drain_wait", 32'(st), 32'd5);
        tk();
        chk("s2_load", 32'(st), 32'd1);
        chk("s2_load_corerst", 32'(core_rst_n), 32'd0);
        chk("s2_load_pn", 32'(pn), 32'd0);
        cyc();
        chk("s2_reset", 32'(st), 32'd2);
        chk("s2_pn", 32'(pn), 32'd3);
        chk("s2_rate", rate, 32'h0200_0000);
        repeat (3) cyc();
        chk("s2_reset_last", 32'(st), 32'd2);
        cyc();
        chk("s2_settle", 32'(st), 32'd3);
        tk();
        tk();
        chk("s2_run", 32'(st), 32'd4);
        chk("s2_run_mute", 32'(mute), 32'd0);

        // Rejected apply, then boundary-valid apply with shape fields
        wr(2'd0, 32'd9);
        wr(2'd3, 32'h3);
        chk("s3_err", 32'(err), 32'd1);
        chk("s3_rej_state", 32'(st), 32'd4);
        chk("s3_rej_mute", 32'(mute), 32'd0);
        cyc();
        chk("s3_rej_hold", 32'(st), 32'd4);
        chk("s3_rej_pn", 32'(pn), 32'd3);
        wr(2'd0, 32'd6);
        wr(2'd2, 32'h0000_02A5);
        wr(2'd3, 32'h3);
        chk("s3_err_clr", 32'(err), 32'd0);
        chk("s3_drain", 32'(st), 32'd5);
        tk();
        cyc();
        chk("s3_pn", 32'(pn), 32'd6);
        chk("s3_edge", 32'(edge_t), 32'hA5);
        chk("s3_filt", 32'(filt), 32'd2);
        repeat (4) cyc();
        tk();
        tk();
        chk("s3_run", 32'(st), 32'd4);
        wr(2'd1, 32'd0);
        wr(2'd3, 32'h3);
        chk("s3_rate0_err", 32'(err), 32'd1);
        chk("s3_rate0_state", 32'(st), 32'd4);
        chk("s3_rate0_rate", rate, 32'h0200_0000);
        wr(2'd1, 32'h0300_0000);
        chk("s3_err_sticky", 32'(err), 32'd1);

        // Load protection during RUN
        ch_load_protect = 1'b1;
        #1;
        chk("s4_mute_comb", 32'(mute), 32'd1);
        chk("s4_state_pre", 32'(st), 32'd4);
        cyc();
        chk("s4_protect", 32'(st), 32'd6);
        chk("s4_corerst", 32'(core_rst_n), 32'd1);
        chk("s4_busy", 32'(busy), 32'd1);
        cyc();
        chk("s4_hold", 32'(st), 32'd6);
        ch_load_protect = 1'b0;
        cyc();
        chk("s4_settle", 32'(st), 32'd3);
        chk("s4_settle_mute", 32'(mute), 32'd1);
        tk();
        tk();
        chk("s4_run", 32'(st), 32'd4);
        chk("s4_run_mute", 32'(mute), 32'd0);
        chk("s4_pn", 32'(pn), 32'd6);
        chk("s4_rate", rate, 32'h0200_0000);

        // Protect, run=0 and apply together
        wr(2'd0, 32'd2);
        ch_load_protect = 1'b1;
        host_wr_en      = 1'b1;
        host_addr       = 2'd3;
        host_wdata      = 32'h2;
        cyc();
        host_wr_en = 1'b0;
        chk("s5_protect", 32'(st), 32'd6);
        chk("s5_accept", 32'(err), 32'd0);
        cyc();
        chk("s5_hold", 32'(st), 32'd6);
        ch_load_protect = 1'b0;
        cyc();
        chk("s5_idle", 32'(st), 32'd0);
        chk("s5_idle_corerst", 32'(core_rst_n), 32'd0);
        chk("s5_idle_mute", 32'(mute), 32'd1);
        chk("s5_idle_pn", 32'(pn), 32'd6);
        cyc();
        chk("s5_idle_hold", 32'(st), 32'd0);
        wr(2'd3, 32'h1);
        cyc();
        chk("s5_load", 32'(st), 32'd1);
        cyc();
        chk("s5_reset", 32'(st), 32'd2);
        chk("s5_pn", 32'(pn), 32'd2);
        chk("s5_rate", rate, 32'h0300_0000);

        // Asynchronous reset during SETTLE
        repeat (3) cyc();
        tk();
        chk("s6_settle", 32'(st), 32'd3);
        wr(2'd0, 32'd9);
        wr(2'd3, 32'h3);
        chk("s6_err", 32'(err), 32'd1);
        chk("s6_settle_hold", 32'(st), 32'd3);
        reset_n = 1'b0;
        #1;
        chk_reset_vals("s6_async");
        @(negedge dac_clk);
        reset_n = 1'b1;
        repeat (4) cyc();
        chk("s6_post_state", 32'(st), 32'd0);
        chk("s6_post_pn", 32'(pn), 32'd0);
        chk("s6_post_rate", rate, 32'h0100_0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
